stack_seq: RTL and testbench

Operation sequencer for the tinycpu 8-entry, 16-bit hardware stack. It is the initiator side of the stack port: it accepts stack micro-ops over a valid/ready handshake and drives `load`/`push`/`pop`/`d`. It reads back `qtop`/`qnext`, tracks occupancy, and flags overflow, underflow and illegal opcodes. It sits between the tinycpu decoder and the stack register file.

---
 rtl/tinycpu_stack_pkg.sv | 51 +++++
 rtl/stack_alu.sv | 25 ++
 rtl/stack_seq.sv | 169 ++++++++++++++++
 tb/tb_stack_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinycpu_stack_pkg.sv
// Shared definitions for the tinycpu hardware stack: opcodes, sequencer states, sizes,
// and per-opcode depth requirements.
package tinycpu_stack_pkg;

  localparam int unsigned STACK_DEPTH = 8;
  localparam int unsigned STACK_W     = 16;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PUSHI = 4'h1;
  localparam logic [3:0] OP_DROP  = 4'h2;
  localparam logic [3:0] OP_DUP   = 4'h3;
  localparam logic [3:0] OP_OVER  = 4'h4;
  localparam logic [3:0] OP_SWAP  = 4'h5;
  localparam logic [3:0] OP_ADD   = 4'h6;
  localparam logic [3:0] OP_SUB   = 4'h7;
  localparam logic [3:0] OP_AND   = 4'h8;
  localparam logic [3:0] OP_OR    = 4'h9;
  localparam logic [3:0] OP_XOR   = 4'hA;
  localparam logic [3:0] OP_OUT   = 4'hB;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSwap2   = 2'd1,
    StOutWait = 2'd2
  } seq_state_e;

  // Minimum number of valid entries an opcode needs before it may execute.
  function automatic logic [1:0] op_need(input logic [3:0] op);
    logic [1:0] need;
    case (op)
      OP_DROP, OP_DUP, OP_OUT:                           need = 2'd1;
      OP_OVER, OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR:                                            need = 2'd2;
      default:                                           need = 2'd0;
    endcase
    return need;
  endfunction

  function automatic logic op_grows(input logic [3:0] op);
    return (op == OP_PUSHI) || (op == OP_DUP) || (op == OP_OVER);
  endfunction

  function automatic logic op_is_binary(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_OUT;
  endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational two-operand ALU for the stack binary ops: y = N op T, modulo 2^W.
module stack_alu
  import tinycpu_stack_pkg::*;
#(
  parameter int unsigned W = STACK_W
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] n,
  input  logic [W-1:0] t,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = n + t;
      OP_SUB:  y = n - t;
      OP_AND:  y = n & t;
      OP_OR:   y = n | t;
      OP_XOR:  y = n ^ t;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/stack_seq.sv
// Stack micro-op sequencer: accepts ops over valid/ready, drives the stack port
// combinationally, tracks occupancy and raises sticky overflow/underflow/illegal flags.
module stack_seq
  import tinycpu_stack_pkg::*;
#(
  parameter int unsigned DEPTH = STACK_DEPTH,
  parameter int unsigned W     = STACK_W,
  localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [3:0]    op,
  input  logic [W-1:0]  imm,
  output logic          stk_load,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [W-1:0]  stk_d,
  input  logic [W-1:0]  stk_qtop,
  input  logic [W-1:0]  stk_qnext,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic [DW-1:0] depth,
  output logic          err_ovf,
  output logic          err_unf,
  output logic          err_ill,
  input  logic          clr_err
);

  seq_state_e    state_q;
  logic [DW-1:0] depth_q;
  logic [W-1:0]  temp_q;
  logic          ovf_q, unf_q, ill_q;

  logic          accept;
  logic          bad_ill, bad_unf, bad_ovf;
  logic          op_ok;
  logic [W-1:0]  alu_y;

  stack_alu #(
    .W (W)
  ) u_alu (
    .op (op),
    .n  (stk_qnext),
    .t  (stk_qtop),
    .y  (alu_y)
  );

  assign op_ready = (state_q == StIdle);
  assign accept   = op_valid && op_ready;

  // Illegal opcodes report only err_ill; depth checks apply to legal opcodes.
  assign bad_ill = op_illegal(op);
  assign bad_unf = !bad_ill && (depth_q < DW'(op_need(op)));
  assign bad_ovf = !bad_ill && op_grows(op) && (depth_q == DW'(DEPTH));
  assign op_ok   = accept && !bad_ill && !bad_unf && !bad_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      depth_q <= '0;
      temp_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      // A new error in the same cycle as clr_err leaves the flag set.
      ovf_q <= (ovf_q && !clr_err) || (accept && bad_ovf);
      unf_q <= (unf_q && !clr_err) || (accept && bad_unf);
      ill_q <= (ill_q && !clr_err) || (accept && bad_ill);

      unique case (state_q)
        StIdle: begin
          if (op_ok) begin
            if (op_grows(op)) begin
              depth_q <= depth_q + 1'b1;
            end else if ((op == OP_DROP) || op_is_binary(op)) begin
              depth_q <= depth_q - 1'b1;
            end
            if (op == OP_SWAP) begin
              temp_q  <= stk_qnext;
              state_q <= StSwap2;
            end else if (op == OP_OUT) begin
              state_q <= StOutWait;
            end
          end
        end
        StSwap2: begin
          state_q <= StIdle;
        end
        StOutWait: begin
          if (res_ready) begin
            depth_q <= depth_q - 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Stack commands are combinational so the stack updates on the accepting edge.
  always_comb begin
    stk_load = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (op_ok) begin
          case (op)
            OP_PUSHI: begin
              stk_load = 1'b1;
              stk_push = 1'b1;
              stk_d    = imm;
            end
            OP_DUP: begin
              stk_load = 1'b1;
              stk_push = 1'b1;
              stk_d    = stk_qtop;
            end
            OP_OVER: begin
              stk_load = 1'b1;
              stk_push = 1'b1;
              stk_d    = stk_qnext;
            end
            OP_DROP: begin
              stk_pop = 1'b1;
            end
            OP_SWAP: begin
              stk_load = 1'b1;
              stk_pop  = 1'b1;
              stk_d    = stk_qtop;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              stk_load = 1'b1;
              stk_pop  = 1'b1;
              stk_d    = alu_y;
            end
            default: begin
            end
          endcase
        end
      end
      StSwap2: begin
        stk_load = 1'b1;
        stk_push = 1'b1;
        stk_d    = temp_q;
      end
      StOutWait: begin
        stk_pop = res_ready;
      end
      default: begin
      end
    endcase
  end

  assign res_valid = (state_q == StOutWait);
  assign res_data  = res_valid ? stk_qtop : '0;
  assign depth     = depth_q;
  assign err_ovf   = ovf_q;
  assign err_unf   = unf_q;
  assign err_ill   = ill_q;

endmodule

// File: tb/tb_stack_seq.sv
// Randomised scoreboard bench for stack_seq with a queue-based stack reference model.
module tb_stack_seq;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned W     = 16;

  localparam logic [3:0] NOP = 4'h0, PUSHI = 4'h1, DROP = 4'h2, DUP = 4'h3, OVER = 4'h4;
  localparam logic [3:0] SWAP = 4'h5, ADD = 4'h6, SUB = 4'h7, OUT = 4'hB;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid;
  logic          op_ready;
  logic [3:0]    op;
  logic [W-1:0]  imm;
  logic          stk_load, stk_push, stk_pop;
  logic [W-1:0]  stk_d;
  logic [W-1:0]  stk_qtop, stk_qnext;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic [3:0]    depth;
  logic          err_ovf, err_unf, err_ill;
  logic          clr_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit rr_rand  = 1'b0;

  logic [W-1:0] ref_q[$];    // front = top of stack
  logic [W-1:0] exp_res[$];  // scoreboard of expected OUT results
  bit r_ovf, r_unf, r_ill;

  always #5 clk = ~clk;

  stack_seq #(
    .DEPTH (DEPTH),
    .W     (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .imm       (imm),
    .stk_load  (stk_load),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_d     (stk_d),
    .stk_qtop  (stk_qtop),
    .stk_qnext (stk_qnext),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .depth     (depth),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf),
    .err_ill   (err_ill),
    .clr_err   (clr_err)
  );

  // The stack register file the sequencer drives.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (stk_load && stk_push) begin
      mem[0] <= stk_d;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end else if (stk_load && stk_pop) begin
      mem[0] <= stk_d;
      for (int i = 1; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      mem[DEPTH-1] <= '0;
    end else if (stk_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      mem[DEPTH-1] <= '0;
    end
  end
  assign stk_qtop  = mem[0];
  assign stk_qnext = mem[1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_need(input logic [3:0] o);
    if (o == DROP || o == DUP || o == OUT) return 1;
    if (o >= OVER && o <= 4'hA) return 2;
    return 0;
  endfunction

  function automatic logic [W-1:0] ref_bin(input logic [3:0] o, input logic [W-1:0] n,
                                           input logic [W-1:0] t);
    case (o)
      4'h6:    return n + t;
      4'h7:    return n - t;
      4'h8:    return n & t;
      4'h9:    return n | t;
      default: return n ^ t;
    endcase
  endfunction

  // Applies one accepted op to the reference; returns whether a stack command is due at accept.
  function automatic bit ref_apply(input logic [3:0] o, input logic [W-1:0] im, input bit clr);
    int sz;
    logic [W-1:0] t, n;
    sz = ref_q.size();
    if (clr) begin
      r_ovf = 0;
      r_unf = 0;
      r_ill = 0;
    end
    if (o > OUT) begin
      r_ill = 1;
      return 0;
    end
    if (sz < ref_need(o)) begin
      r_unf = 1;
      return 0;
    end
    if ((o == PUSHI || o == DUP || o == OVER) && sz == DEPTH) begin
      r_ovf = 1;
      return 0;
    end
    case (o)
      PUSHI: ref_q.push_front(im);
      DROP:  void'(ref_q.pop_front());
      DUP:   ref_q.push_front(ref_q[0]);
      OVER:  ref_q.push_front(ref_q[1]);
      SWAP: begin
        t = ref_q[0];
        ref_q[0] = ref_q[1];
        ref_q[1] = t;
      end
      OUT: begin
        exp_res.push_back(ref_q.pop_front());
        return 0;
      end
      NOP:   return 0;
      default: begin
        t = ref_q.pop_front();
        n = ref_q.pop_front();
        ref_q.push_front(ref_bin(o, n, t));
      end
    endcase
    return 1;
  endfunction

  task automatic ref_reset();
    ref_q.delete();
    exp_res.delete();
    r_ovf = 0;
    r_unf = 0;
    r_ill = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_depth"}, 32'(depth), 32'(ref_q.size()));
    chk({tag, "_flags"}, {29'd0, err_ovf, err_unf, err_ill}, {29'd0, r_ovf, r_unf, r_ill});
    if (ref_q.size() > 0) chk({tag, "_qtop"}, 32'(stk_qtop), 32'(ref_q[0]));
    if (ref_q.size() > 1) chk({tag, "_qnext"}, 32'(stk_qnext), 32'(ref_q[1]));
  endtask

  // Issues one op, waits for the sequencer to return to idle, then checks state.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] im, input bit clr,
                       output int stall);
    int guard;
    bit exp_cmd;
    @(posedge clk); #1;
    guard = 0;
    while (!op_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!op_ready) chk("ready_timeout", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op       = o;
    imm      = im;
    clr_err  = clr;
    exp_cmd  = ref_apply(o, im, clr);
    @(negedge clk);
    chk("cmd_at_accept", 32'(stk_load | stk_push | stk_pop), 32'(exp_cmd));
    @(posedge clk); #1;
    op_valid = 1'b0;
    op       = '0;
    imm      = '0;
    clr_err  = 1'b0;
    stall    = 0;
    while (!op_ready && stall < 200) begin
      @(posedge clk); #1;
      stall++;
    end
    if (!op_ready) chk("idle_timeout", 32'(op_ready), 32'd1);
    @(negedge clk);
    check_state("op");
  endtask

  // Scoreboard monitor and output gating invariants.
  always @(negedge clk) begin
    if (reset) begin
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
        else chk("res_data", 32'(res_data), 32'(exp_res.pop_front()));
      end
      if (!stk_load) chk("stk_d_gated", 32'(stk_d), 32'd0);
      if (!res_valid) chk("res_data_gated", 32'(res_data), 32'd0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rr_rand) res_ready = ($urandom_range(0, 2) == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int st;
    logic [3:0] ro;
    op_valid  = 1'b0;
    op        = '0;
    imm       = '0;
    clr_err   = 1'b0;
    res_ready = 1'b0;
    ref_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_flags", {29'd0, err_ovf, err_unf, err_ill}, 32'd0);
    chk("rst_cmds", {29'd0, stk_load, stk_push, stk_pop}, 32'd0);
    chk("rst_stk_d", 32'(stk_d), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Arithmetic and OUT with an always-ready consumer.
    res_ready = 1'b1;
    issue(PUSHI, 16'h0003, 0, st);
    chk("sub_q1", 32'(stk_qtop), 32'h0003);
    issue(PUSHI, 16'h0005, 0, st);
    chk("sub_q2", 32'(stk_qtop), 32'h0005);
    issue(SUB, 16'h0, 0, st);
    chk("sub_q3", 32'(stk_qtop), 32'hFFFE);
    issue(OUT, 16'h0, 0, st);
    chk("out_depth", 32'(depth), 32'd0);

    // SWAP stalls op_ready for exactly one cycle.
    issue(PUSHI, 16'h1111, 0, st);
    issue(PUSHI, 16'h2222, 0, st);
    issue(SWAP, 16'h0, 0, st);
    chk("swap_stall", 32'(st), 32'd1);
    chk("swap_qtop", 32'(stk_qtop), 32'h1111);
    chk("swap_qnext", 32'(stk_qnext), 32'h2222);
    issue(DROP, 16'h0, 0, st);
    issue(DROP, 16'h0, 0, st);

    // Overflow on the ninth push; error beats clr_err; plain clear.
    for (int i = 0; i < 9; i++) issue(PUSHI, 16'h00AA, 0, st);
    chk("ovf_flag", 32'(err_ovf), 32'd1);
    chk("ovf_depth", 32'(depth), 32'd8);
    issue(PUSHI, 16'h00AA, 1, st);
    chk("ovf_beats_clr", 32'(err_ovf), 32'd1);
    issue(NOP, 16'h0, 1, st);
    chk("ovf_cleared", 32'(err_ovf), 32'd0);
    for (int i = 0; i < 8; i++) issue(DROP, 16'h0, 0, st);

    // Underflow cases.
    issue(DROP, 16'h0, 0, st);
    chk("unf_drop", 32'(err_unf), 32'd1);
    issue(NOP, 16'h0, 1, st);
    issue(PUSHI, 16'h0042, 0, st);
    issue(ADD, 16'h0, 0, st);
    chk("unf_add_flag", 32'(err_unf), 32'd1);
    chk("unf_add_depth", 32'(depth), 32'd1);
    issue(NOP, 16'h0, 1, st);

    // OUT held by a stalled consumer.
    rr_rand   = 1'b0;
    res_ready = 1'b0;
    issue(PUSHI, 16'h1234, 0, st);
    @(posedge clk); #1;
    op_valid = 1'b1;
    op       = OUT;
    void'(ref_apply(OUT, 16'h0, 0));
    @(posedge clk); #1;
    op_valid = 1'b0;
    op       = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), 32'h1234);
      chk("hold_ready", 32'(op_ready), 32'd0);
      chk("hold_nopop", 32'(stk_pop), 32'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("hold_pop", 32'(stk_pop), 32'd1);
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check_state("hold_done");

    // Asynchronous reset while in SWAP2.
    issue(PUSHI, 16'h0A0A, 0, st);
    @(posedge clk); #1;
    op_valid = 1'b1;
    op       = SWAP;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op       = '0;
    chk("swap2_ready", 32'(op_ready), 32'd0);
    chk("swap2_cmd", 32'(stk_load & stk_push), 32'd1);
    reset = 1'b0;
    #1;
    ref_reset();
    chk("mid_rst_ready", 32'(op_ready), 32'd1);
    chk("mid_rst_cmds", {29'd0, stk_load, stk_push, stk_pop}, 32'd0);
    chk("mid_rst_stk_d", 32'(stk_d), 32'd0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    chk("mid_rst_res", 32'(res_valid), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    issue(PUSHI, 16'h0007, 0, st);
    chk("post_rst_qtop", 32'(stk_qtop), 32'h0007);
    chk("post_rst_depth", 32'(depth), 32'd1);
    issue(4'hE, 16'h0, 0, st);
    chk("ill_only", {29'd0, err_ovf, err_unf, err_ill}, 32'd1);

    // Randomised traffic against the reference model.
    rr_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 30) ro = PUSHI;
      else ro = 4'($urandom_range(0, 15));
      issue(ro, 16'($urandom), ($urandom_range(0, 9) == 0), st);
    end
    rr_rand = 1'b0;

    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_res.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
